fx_cfg_sequencer: RTL and testbench
===================================

Name: fx_cfg_sequencer

Overview:
- Sits between the UART command decoder and the audio effect datapath (filter/echo/remix/pitch).
- Watches the decoder's 8-bit mode code and 32-bit parameter word. Once a new setting has been stable, it fades the output gain down, hands the setting to the datapath over a valid/ready handshake, then fades the gain back up.
- Guarantees glitch-free effect switching, with every gain change aligned to audio sample ticks.

Parameters:
- STABLE_CYC, 16: number of consecutive clk cycles the mode/param inputs must be unchanged before a switch is committed (min 1).
- FADE_STEP, 8: gain increment/decrement applied per sample_tick during fades (1..GAIN_MAX).
- GAIN_MAX, 128: unity gain code (full-scale value of gain output, max 255).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- mode_in  in  8  decoder mode code (0 idle, 1 filter, 2 echo, 3 remix, 4 up, 5 down, 10-14 filter stages, 20/21 remix S/M); treated as opaque.
- param_in  in  32  decoder parameter word; treated as opaque.
- sample_tick  in  1  one-cycle pulse per audio sample.
- cfg_ready  in  1  datapath accepts configuration.
- cfg_valid  out  1  configuration offer.
- cfg_mode  out  8  mode being offered/last applied.
- cfg_param  out  32  param being offered/last applied.
- gain  out  8  output gain code, 0..GAIN_MAX.
- busy  out  1  high in any state other than IDLE.
- switch_cnt  out  16  count of completed handshakes, wraps 0xFFFF->0.

Behaviour:
- Reset (async, reset_n low):
  - State IDLE.
  - cfg_valid=0, cfg_mode=0, cfg_param=0, gain=GAIN_MAX, busy=0, switch_cnt=0.
  - Applied setting and snapshot registers cleared to {0,0}.
  - Reset asserted mid-fade or mid-handshake aborts immediately to these values.
- All outputs are registered. Inputs are sampled every clk with no synchroniser, since they share the clk domain.
- State IDLE:
  - gain holds GAIN_MAX.
  - If {mode_in,param_in} != applied: snapshot<=inputs, stab_cnt<=0, go to SETTLE.
- State SETTLE:
  - If inputs != snapshot: snapshot<=inputs, stab_cnt<=0 (restart).
  - Else if snapshot == applied: return to IDLE.
  - Else stab_cnt++.
  - When stab_cnt reaches STABLE_CYC-1 with inputs unchanged: target<=snapshot, go to FADE_OUT.
  - Minimum IDLE-to-FADE_OUT latency is STABLE_CYC+1 cycles.
- State FADE_OUT:
  - On each sample_tick: gain <= (gain>FADE_STEP) ? gain-FADE_STEP : 0.
  - The cycle after gain is 0, go to REQ. gain updates only on sample_tick.
  - Input changes are ignored until the sequence completes.
- State REQ:
  - cfg_valid=1 with cfg_mode/cfg_param=target, all held stable while cfg_ready is low (no timeout).
  - On the cycle where cfg_valid&&cfg_ready: applied<=target, switch_cnt++, cfg_valid<=0 next cycle, go to FADE_IN.
  - cfg_ready high outside REQ is ignored.
- State FADE_IN:
  - On each sample_tick: gain <= min(gain+FADE_STEP, GAIN_MAX), computed in 9 bits, so there is no 8-bit wrap.
  - Go to IDLE the cycle after gain==GAIN_MAX.
- Boundary cases:
  - Inputs that changed during FADE_OUT/REQ/FADE_IN are seen by the first IDLE comparison.
  - Inputs that return to the applied value during SETTLE cause no switch and leave gain untouched.
  - sample_tick coincident with a state entry is honoured in the new state on the following tick only.
- cfg_mode/cfg_param hold the last applied values outside REQ.

Optional Feature:
- Macro FX_CFG_FADE_EN.
- Defined: fade behaviour exactly as above.
- Undefined:
  - FADE_OUT and FADE_IN states are removed; SETTLE goes directly to REQ, and the handshake goes directly to IDLE.
  - gain is constant GAIN_MAX and sample_tick is unused.
  - All other behaviour is unchanged.

Test Plan:
- Reset, inputs {0,0} for 100 cycles -> busy=0, gain=128, cfg_valid=0, switch_cnt=0.
- mode_in 0->1, param 0x00000003, held; sample_tick every 10 clk; cfg_ready=1 -> after 17 clk gain steps 128,120,...,0 (16 ticks); one-cycle cfg_valid with cfg_mode=1, cfg_param=3; gain ramps back to 128; switch_cnt=1; busy falls.
- Param toggled 3->4->3 within 10 cycles while applied=3 -> no FADE_OUT, gain stays 128, switch_cnt unchanged.
- mode_in=2 with cfg_ready=0 for 50 cycles after REQ entry -> cfg_valid, cfg_mode=2 and gain=0 held; cfg_ready=1 -> handshake in that cycle, fade-in follows.
- mode_in changed to 20 during FADE_IN of a switch to 1 -> fade-in completes to 128, then a second full sequence applies mode 20; switch_cnt +2.
- reset_n pulsed low during FADE_OUT (gain=64) -> gain=128, cfg_valid=0, state IDLE immediately; with FX_CFG_FADE_EN undefined, a mode change yields a handshake after STABLE_CYC+1 cycles and gain=128 throughout.

Source files
------------

// File: rtl/fx_cfg_sequencer.sv
// Debounces the decoder mode/param word, then fades gain out, offers the setting over valid/ready and fades back in.
// REQ holds cfg_valid/cfg_mode/cfg_param indefinitely while cfg_ready is low; define FX_CFG_FADE_EN to enable the gain fades.
module fx_cfg_sequencer #(
  parameter int STABLE_CYC = 16,
  parameter int FADE_STEP  = 8,
  parameter int GAIN_MAX   = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  mode_in,
  input  logic [31:0] param_in,
  input  logic        sample_tick,
  input  logic        cfg_ready,
  output logic        cfg_valid,
  output logic [7:0]  cfg_mode,
  output logic [31:0] cfg_param,
  output logic [7:0]  gain,
  output logic        busy,
  output logic [15:0] switch_cnt
);

  localparam int SW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYC - 1);
  localparam logic [7:0] GMAX = 8'(GAIN_MAX);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_FADE_OUT, S_REQ, S_FADE_IN} state_t;

  state_t        state_q, state_d;
  logic [39:0]   snap_q, snap_d;
  logic [39:0]   target_q, target_d;
  logic [39:0]   applied_q, applied_d;
  logic [SW-1:0] stab_q, stab_d;
  logic          vld_q, vld_d;
  logic [7:0]    mode_q, mode_d;
  logic [31:0]   param_q, param_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          busy_q;
  logic [39:0]   in_w;

  assign in_w = {mode_in, param_in};

`ifdef FX_CFG_FADE_EN
  localparam logic [7:0] FSTEP = 8'(FADE_STEP);
  localparam logic [8:0] GMAX9 = 9'(GAIN_MAX);
  logic [7:0] gain_q, gain_d, gain_up, gain_dn;
  logic [8:0] gain_sum;

  // Fade-in sum is 9 bits wide so a large step clamps instead of wrapping.
  assign gain_sum = {1'b0, gain_q} + {1'b0, FSTEP};
  assign gain_up  = (gain_sum > GMAX9) ? GMAX : gain_sum[7:0];
  assign gain_dn  = (gain_q > FSTEP) ? (gain_q - FSTEP) : 8'd0;
  assign gain     = gain_q;
`else
  logic unused_tick;
  assign unused_tick = sample_tick;
  assign gain        = GMAX;
`endif

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    stab_d    = stab_q;
    target_d  = target_q;
    applied_d = applied_q;
    vld_d     = vld_q;
    mode_d    = mode_q;
    param_d   = param_q;
    cnt_d     = cnt_q;
`ifdef FX_CFG_FADE_EN
    gain_d    = gain_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_w != applied_q) begin
          snap_d  = in_w;
          stab_d  = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (in_w != snap_q) begin
          snap_d = in_w;
          stab_d = '0;
        end else if (snap_q == applied_q) begin
          state_d = S_IDLE;
        end else if (stab_q == STAB_LAST) begin
          target_d = snap_q;
`ifdef FX_CFG_FADE_EN
          state_d  = S_FADE_OUT;
`else
          state_d  = S_REQ;
          vld_d    = 1'b1;
          mode_d   = snap_q[39:32];
          param_d  = snap_q[31:0];
`endif
        end else begin
          stab_d = stab_q + SW'(1);
        end
      end
`ifdef FX_CFG_FADE_EN
      S_FADE_OUT: begin
        if (gain_q == 8'd0) begin
          state_d = S_REQ;
          vld_d   = 1'b1;
          mode_d  = target_q[39:32];
          param_d = target_q[31:0];
        end else if (sample_tick) begin
          gain_d = gain_dn;
        end
      end
      S_FADE_IN: begin
        if (gain_q == GMAX) begin
          state_d = S_IDLE;
        end else if (sample_tick) begin
          gain_d = gain_up;
        end
      end
`endif
      S_REQ: begin
        if (vld_q && cfg_ready) begin
          applied_d = target_q;
          cnt_d     = cnt_q + 16'd1;
          vld_d     = 1'b0;
`ifdef FX_CFG_FADE_EN
          state_d   = S_FADE_IN;
`else
          state_d   = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      snap_q    <= '0;
      stab_q    <= '0;
      target_q  <= '0;
      applied_q <= '0;
      vld_q     <= 1'b0;
      mode_q    <= '0;
      param_q   <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
`ifdef FX_CFG_FADE_EN
      gain_q    <= GMAX;
`endif
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      stab_q    <= stab_d;
      target_q  <= target_d;
      applied_q <= applied_d;
      vld_q     <= vld_d;
      mode_q    <= mode_d;
      param_q   <= param_d;
      cnt_q     <= cnt_d;
      busy_q    <= (state_d != S_IDLE);
`ifdef FX_CFG_FADE_EN
      gain_q    <= gain_d;
`endif
    end
  end

  assign cfg_valid  = vld_q;
  assign cfg_mode   = mode_q;
  assign cfg_param  = param_q;
  assign busy       = busy_q;
  assign switch_cnt = cnt_q;

endmodule

// File: tb/tb_fx_cfg_sequencer.sv
// Directed bench for fx_cfg_sequencer; expectations follow FX_CFG_FADE_EN when it is defined.
module tb_fx_cfg_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  mode_in;
  logic [31:0] param_in;
  logic        sample_tick;
  logic        cfg_ready;
  logic        cfg_valid;
  logic [7:0]  cfg_mode;
  logic [31:0] cfg_param;
  logic [7:0]  gain;
  logic        busy;
  logic [15:0] switch_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_cnt = 0;

`ifdef FX_CFG_FADE_EN
  localparam logic [7:0] HOLD_GAIN = 8'd0;
`else
  localparam logic [7:0] HOLD_GAIN = 8'd128;
`endif

  fx_cfg_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode_in    (mode_in),
    .param_in   (param_in),
    .sample_tick(sample_tick),
    .cfg_ready  (cfg_ready),
    .cfg_valid  (cfg_valid),
    .cfg_mode   (cfg_mode),
    .cfg_param  (cfg_param),
    .gain       (gain),
    .busy       (busy),
    .switch_cnt (switch_cnt)
  );

  initial forever #10 clk = ~clk;

  // One-cycle sample tick every 10 clocks.
  initial begin
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_cnt++;
      sample_tick = (tick_cnt % 10 == 0);
    end
  end

  // Steps negedges, recording offers and gain behaviour; k counts posedges since the call.
  task automatic observe(input int max_cyc, input bit stop_on_vld,
                         input logic [7:0] em, input logic [31:0] ep,
                         output int first_vld, output int n_vld, output int bad_gain,
                         output int bad_offer, output logic [7:0] gmin, output bit timeout);
    logic [7:0] prev;
    first_vld = -1; n_vld = 0; bad_gain = 0; bad_offer = 0;
    gmin = gain; prev = gain; timeout = 1'b1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      if (gain < gmin) gmin = gain;
`ifdef FX_CFG_FADE_EN
      if (gain !== prev && gain !== ((prev > 8'd8) ? prev - 8'd8 : 8'd0) &&
          gain !== ((prev > 8'd120) ? 8'd128 : prev + 8'd8)) bad_gain++;
`else
      if (gain !== 8'd128) bad_gain++;
`endif
      prev = gain;
      if (cfg_valid) begin
        if (first_vld < 0) first_vld = k;
        n_vld++;
        if (cfg_mode !== em || cfg_param !== ep) bad_offer++;
      end
      if ((stop_on_vld && cfg_valid) || (!stop_on_vld && n_vld > 0 && !busy && !cfg_valid)) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mode_in = 8'd0; param_in = 32'd0; cfg_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (gain !== 8'd128) begin n_fail++; $display("FAIL reset_gain_in_reset: got %0d want 128", gain); end
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (gain !== 8'd128) begin n_fail++; $display("FAIL reset_gain: got %0d want 128", gain); end
    n_tests++; if (cfg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", cfg_valid); end
    n_tests++; if (switch_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", switch_cnt); end
    n_tests++; if (cfg_mode !== 8'd0 || cfg_param !== 32'd0) begin n_fail++; $display("FAIL reset_cfg: got %0d/%0h want 0/0", cfg_mode, cfg_param); end
  endtask

  task automatic test_basic_switch();
    int fv, nv, bg, bo; logic [7:0] gm; bit to;
    cfg_ready = 1'b1; mode_in = 8'd1; param_in = 32'd3;
    observe(4000, 1'b0, 8'd1, 32'd3, fv, nv, bg, bo, gm, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: sequence did not complete"); end
    n_tests++; if (nv !== 1) begin n_fail++; $display("FAIL basic_valid_cycles: got %0d want 1", nv); end
    n_tests++; if (bo !== 0) begin n_fail++; $display("FAIL basic_offer: %0d bad offer cycles want 0", bo); end
    n_tests++; if (bg !== 0) begin n_fail++; $display("FAIL basic_gain_steps: %0d bad gain samples want 0", bg); end
    n_tests++; if (gm !== HOLD_GAIN) begin n_fail++; $display("FAIL basic_gain_min: got %0d want %0d", gm, HOLD_GAIN); end
`ifdef FX_CFG_FADE_EN
    n_tests++; if (fv < 169) begin n_fail++; $display("FAIL basic_latency: got %0d want >=169", fv); end
`else
    n_tests++; if (fv !== 17) begin n_fail++; $display("FAIL basic_latency: got %0d want 17", fv); end
`endif
    n_tests++; if (switch_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_cnt: got %0d want 1", switch_cnt); end
    n_tests++; if (cfg_mode !== 8'd1 || cfg_param !== 32'd3) begin n_fail++; $display("FAIL basic_applied: got %0d/%0h want 1/3", cfg_mode, cfg_param); end
    n_tests++; if (gain !== 8'd128 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_end: gain %0d busy %b want 128/0", gain, busy); end
  endtask

  task automatic test_bounce();
    int vseen = 0, bad = 0; bit saw_busy = 1'b0;
    param_in = 32'd4;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 2) param_in = 32'd3;
      if (cfg_valid) vseen++;
      if (gain !== 8'd128) bad++;
      if (busy) saw_busy = 1'b1;
    end
    n_tests++; if (saw_busy !== 1'b1) begin n_fail++; $display("FAIL bounce_settle: busy never rose"); end
    n_tests++; if (vseen !== 0) begin n_fail++; $display("FAIL bounce_valid: got %0d valid cycles want 0", vseen); end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL bounce_gain: %0d samples off 128", bad); end
    n_tests++; if (switch_cnt !== 16'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL bounce_end: cnt %0d busy %b want 1/0", switch_cnt, busy); end
  endtask

  task automatic test_ready_stall();
    int fv, nv, bg, bo, bad = 0; logic [7:0] gm; bit to; bit idle = 1'b0;
    cfg_ready = 1'b0; mode_in = 8'd2;
    observe(4000, 1'b1, 8'd2, 32'd3, fv, nv, bg, bo, gm, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL stall_timeout: no offer seen"); end
`ifndef FX_CFG_FADE_EN
    n_tests++; if (fv !== 17) begin n_fail++; $display("FAIL stall_latency: got %0d want 17", fv); end
`endif
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cfg_valid !== 1'b1 || cfg_mode !== 8'd2 || cfg_param !== 32'd3 ||
          gain !== HOLD_GAIN || switch_cnt !== 16'd1) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL stall_hold: %0d unstable cycles want 0", bad); end
    cfg_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (cfg_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid_drop: got %b want 0", cfg_valid); end
    n_tests++; if (switch_cnt !== 16'd2) begin n_fail++; $display("FAIL stall_cnt: got %0d want 2", switch_cnt); end
    for (int k = 0; k < 4000 && !idle; k++) begin
      if (!busy) idle = 1'b1; else @(negedge clk);
    end
    n_tests++; if (idle !== 1'b1 || gain !== 8'd128) begin n_fail++; $display("FAIL stall_fade_in: idle %b gain %0d want 1/128", idle, gain); end
  endtask

  task automatic test_change_during_req();
    int fv, nv, bg, bo; logic [7:0] gm; bit to;
    cfg_ready = 1'b0; mode_in = 8'd1;
    observe(4000, 1'b1, 8'd1, 32'd3, fv, nv, bg, bo, gm, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL change_timeout1: no offer seen"); end
    mode_in = 8'd20;
    repeat (5) @(negedge clk);
    n_tests++; if (cfg_mode !== 8'd1 || cfg_valid !== 1'b1) begin n_fail++; $display("FAIL change_offer_held: mode %0d valid %b want 1/1", cfg_mode, cfg_valid); end
    cfg_ready = 1'b1;
    observe(4000, 1'b0, 8'd20, 32'd3, fv, nv, bg, bo, gm, to);
    n_tests++; if (to !== 1'b0 || nv !== 1 || bo !== 0) begin n_fail++; $display("FAIL change_second: timeout %b valid %0d badoffer %0d want 0/1/0", to, nv, bo); end
    n_tests++; if (bg !== 0) begin n_fail++; $display("FAIL change_gain_steps: %0d bad samples want 0", bg); end
`ifndef FX_CFG_FADE_EN
    n_tests++; if (fv !== 18) begin n_fail++; $display("FAIL change_latency: got %0d want 18", fv); end
`endif
    n_tests++; if (switch_cnt !== 16'd4 || cfg_mode !== 8'd20) begin n_fail++; $display("FAIL change_end: cnt %0d mode %0d want 4/20", switch_cnt, cfg_mode); end
  endtask

  task automatic test_reset_mid();
    int fv, nv, bg, bo; logic [7:0] gm; bit to; bit hit = 1'b0;
    mode_in = 8'd3;
`ifdef FX_CFG_FADE_EN
    cfg_ready = 1'b1;
    for (int k = 0; k < 4000 && !hit; k++) begin
      @(negedge clk);
      if (gain == 8'd64) hit = 1'b1;
    end
`else
    cfg_ready = 1'b0;
    observe(4000, 1'b1, 8'd3, 32'd3, fv, nv, bg, bo, gm, to);
    hit = !to;
`endif
    n_tests++; if (hit !== 1'b1) begin n_fail++; $display("FAIL midreset_reach: target point not reached"); end
    #3 reset_n = 1'b0;
    #1;
    n_tests++; if (gain !== 8'd128 || cfg_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_abort: gain %0d valid %b busy %b want 128/0/0", gain, cfg_valid, busy); end
    n_tests++; if (switch_cnt !== 16'd0 || cfg_mode !== 8'd0) begin n_fail++; $display("FAIL midreset_regs: cnt %0d mode %0d want 0/0", switch_cnt, cfg_mode); end
    @(negedge clk);
    mode_in = 8'd5; param_in = 32'h12345678; cfg_ready = 1'b1; reset_n = 1'b1;
    observe(4000, 1'b0, 8'd5, 32'h12345678, fv, nv, bg, bo, gm, to);
    n_tests++; if (to !== 1'b0 || nv !== 1 || bo !== 0) begin n_fail++; $display("FAIL postreset_seq: timeout %b valid %0d badoffer %0d want 0/1/0", to, nv, bo); end
    n_tests++; if (bg !== 0) begin n_fail++; $display("FAIL postreset_gain: %0d bad samples want 0", bg); end
`ifndef FX_CFG_FADE_EN
    n_tests++; if (fv !== 17) begin n_fail++; $display("FAIL postreset_latency: got %0d want 17", fv); end
`endif
    n_tests++; if (switch_cnt !== 16'd1) begin n_fail++; $display("FAIL postreset_cnt: got %0d want 1", switch_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_switch();
    test_bounce();
    test_ready_stall();
    test_change_during_req();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
